// File: rtl/ps2_interface.sv
// -----------------------------------------------------------------------------
// ps2_interface
//   Host-side PS/2 keyboard link controller. It receives device frames and
//   strobes out each valid scan-code byte. It sends host-to-device command
//   bytes using the inhibit / request-to-send handshake. It also flags framing,
//   parity, ack and timeout errors.
//
// Ports
//   CLK       in     system clock, rising edge
//   RST_X     in     asynchronous active-low reset
//   ps2_clk   inout  PS/2 clock, open-drain (driven 0 or released)
//   ps2_data  inout  PS/2 data, open-drain (driven 0 or released)
//   tx_data   in     byte to send to the device
//   tx_en     in     one-cycle transmit request, honoured only when idle
//   rx_data   out    last good received byte, held until the next one
//   rx_en     out    one-cycle strobe when rx_data is updated
//   busy      out    receive frame or transmit in progress
//   err       out    one-cycle pulse on any frame/parity/ack/timeout error
// -----------------------------------------------------------------------------
module ps2_interface #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int FILTER_LEN  = 8,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 2000
) (
    input  logic       CLK,
    input  logic       RST_X,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic [7:0] rx_data,
    output logic       rx_en,
    output logic       busy,
    output logic       err
);

    // Clocks slower than 1 MHz are treated as one cycle per microsecond.
    localparam int CYC_PER_US  = (CLK_FREQ_HZ >= 1_000_000) ? (CLK_FREQ_HZ / 1_000_000) : 1;
    localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
    localparam int TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
    localparam int TMR_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int TMR_W       = $clog2(TMR_MAX + 1);
    localparam int FCNT_W      = $clog2(FILTER_LEN + 1);

    localparam logic [TMR_W-1:0]  INHIBIT_LAST = TMR_W'(INHIBIT_CYC - 1);
    localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [FCNT_W-1:0] FILTER_LAST  = FCNT_W'(FILTER_LEN - 1);

    // ------------------------------------------------------------------
    // Input conditioning: bit 0 = ps2_clk, bit 1 = ps2_data.
    // Each line goes through a 2-flop synchronizer and then a stability filter.
    // The filter output moves only after the synchronized value has
    // differed from it for FILTER_LEN consecutive cycles.
    // ------------------------------------------------------------------
    logic [1:0] line_in;
    logic [1:0] line_filt;

    assign line_in = {ps2_data, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            logic [1:0]        sync_reg;
            logic [FCNT_W-1:0] cnt_reg;
            logic              filt_reg;

            always_ff @(posedge CLK or negedge RST_X) begin
                if (!RST_X) begin
                    sync_reg <= 2'b11;
                    cnt_reg  <= '0;
                    filt_reg <= 1'b1;
                end else begin
                    sync_reg <= {sync_reg[0], line_in[gi]};
                    if (sync_reg[1] == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == FILTER_LAST) begin
                        filt_reg <= sync_reg[1];
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign line_filt[gi] = filt_reg;
        end
    endgenerate

    logic clk_filt;
    logic data_filt;
    logic clk_prev_reg;
    logic fall;

    assign clk_filt  = line_filt[0];
    assign data_filt = line_filt[1];
    assign fall      = clk_prev_reg & ~clk_filt;

    // ------------------------------------------------------------------
    // Link FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE,
        RX,
        TX_INHIBIT,
        TX_START,
        TX_BITS,
        TX_ACK,
        TX_WAIT_IDLE
    } state_t;

    state_t           state_reg;
    logic [3:0]       bit_cnt_reg;
    // RX: bits shift in at the top and end up as {parity, D7..D0}.
    // TX: holds {parity, D7..D0} and shifts out from bit 0.
    logic [8:0]       shift_reg;
    logic [TMR_W-1:0] tmr_reg;
    logic             clk_low_reg;
    logic             data_low_reg;
    logic             timeout_hit;

    assign timeout_hit = (tmr_reg == TIMEOUT_LAST);

    assign ps2_clk  = clk_low_reg  ? 1'b0 : 1'bz;
    assign ps2_data = data_low_reg ? 1'b0 : 1'bz;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            tmr_reg      <= '0;
            clk_low_reg  <= 1'b0;
            data_low_reg <= 1'b0;
            clk_prev_reg <= 1'b1;
            rx_data      <= 8'h00;
            rx_en        <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            rx_en        <= 1'b0;
            err          <= 1'b0;
            clk_prev_reg <= clk_filt;

            case (state_reg)
                IDLE: begin
                    tmr_reg      <= '0;
                    clk_low_reg  <= 1'b0;
                    data_low_reg <= 1'b0;
                    // A device start bit wins over a simultaneous transmit request.
                    if (fall && !data_filt) begin
                        state_reg   <= RX;
                        bit_cnt_reg <= 4'd1;
                        busy        <= 1'b1;
                    end else if (tx_en) begin
                        shift_reg   <= {~^tx_data, tx_data};
                        clk_low_reg <= 1'b1;
                        state_reg   <= TX_INHIBIT;
                        busy        <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                RX: begin
                    if (fall) begin
                        tmr_reg <= '0;
                        if (bit_cnt_reg == 4'd10) begin
                            // This edge carries the stop bit. shift_reg holds {P, D}.
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                            if ((^shift_reg) && data_filt) begin
                                rx_data <= shift_reg[7:0];
                                rx_en   <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            shift_reg   <= {data_filt, shift_reg[8:1]};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end else if (timeout_hit) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        tmr_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                    end
                end

                TX_INHIBIT: begin
                    if (tmr_reg == INHIBIT_LAST) begin
                        data_low_reg <= 1'b1;
                        tmr_reg      <= '0;
                        state_reg    <= TX_START;
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                    end
                end

                TX_START: begin
                    // Start bit has been on the wire for one cycle, hand the clock over.
                    clk_low_reg <= 1'b0;
                    bit_cnt_reg <= '0;
                    tmr_reg     <= '0;
                    state_reg   <= TX_BITS;
                end

                TX_BITS: begin
                    if (fall) begin
                        tmr_reg <= '0;
                        if (bit_cnt_reg == 4'd9) begin
                            data_low_reg <= 1'b0;      // stop bit = released line
                            state_reg    <= TX_ACK;
                        end else begin
                            data_low_reg <= ~shift_reg[0];
                            shift_reg    <= {1'b1, shift_reg[8:1]};
                            bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                        end
                    end else if (timeout_hit) begin
                        err          <= 1'b1;
                        busy         <= 1'b0;
                        clk_low_reg  <= 1'b0;
                        data_low_reg <= 1'b0;
                        tmr_reg      <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                    end
                end

                TX_ACK: begin
                    if (fall) begin
                        tmr_reg   <= '0;
                        err       <= data_filt;        // device must pull data low to ack
                        state_reg <= TX_WAIT_IDLE;
                    end else if (timeout_hit) begin
                        err          <= 1'b1;
                        busy         <= 1'b0;
                        clk_low_reg  <= 1'b0;
                        data_low_reg <= 1'b0;
                        tmr_reg      <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                    end
                end

                TX_WAIT_IDLE: begin
                    if (clk_filt && data_filt) begin
                        busy      <= 1'b0;
                        tmr_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (timeout_hit) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        tmr_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (fall) begin
                        tmr_reg <= '0;
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                    end
                end

                default: begin
                    clk_low_reg  <= 1'b0;
                    data_low_reg <= 1'b0;
                    busy         <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_interface.sv
// -----------------------------------------------------------------------------
// tb_ps2_interface
//   Scoreboard bench for ps2_interface. The stimulus tasks act as the PS/2
//   device. They push the expected DUT events (good byte or error) into a
//   queue. A monitor pops from that queue and compares whenever rx_en or err
//   fires. Bytes the host sends are captured off the wire and compared against
//   a second queue of expected bytes.
// -----------------------------------------------------------------------------
module tb_ps2_interface;

    localparam int CLK_HZ = 1_000_000;   // one cycle per microsecond
    localparam int FLEN   = 8;
    localparam int INH_US = 100;
    localparam int TO_US  = 400;
    localparam int H      = 20;          // device clock half period, cycles

    logic       CLK = 1'b0;
    logic       RST_X = 1'b0;
    wire        ps2_clk_w;
    wire        ps2_data_w;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       busy;
    logic       err;

    pullup (ps2_clk_w);
    pullup (ps2_data_w);
    assign ps2_clk_w  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data_w = dev_data_low ? 1'b0 : 1'bz;

    ps2_interface #(
        .CLK_FREQ_HZ (CLK_HZ),
        .FILTER_LEN  (FLEN),
        .INHIBIT_US  (INH_US),
        .TIMEOUT_US  (TO_US)
    ) dut (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .ps2_clk  (ps2_clk_w),
        .ps2_data (ps2_data_w),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .rx_data  (rx_data),
        .rx_en    (rx_en),
        .busy     (busy),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       is_err;
        logic [7:0] b;
    } evt_t;

    evt_t       exp_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] last_good = 8'h00;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    evt_t mon_e;
    always @(negedge CLK) begin
        if (RST_X) begin
            if (rx_en && err) begin
                check("rx_en_err_same_cycle", 32'd1, 32'd0);
            end else if (rx_en || err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'd0, rx_en, err}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind_is_err", {31'd0, err}, {31'd0, mon_e.is_err});
                    if (rx_en && !mon_e.is_err)
                        check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.b});
                    if (rx_en) $display("rx event: byte 0x%02h", rx_data);
                    else       $display("rx event: error pulse");
                end
            end
        end
    end

    // ---------------- device -> host frame ----------------
    // nbits < 11 sends a truncated frame. No event is pushed for it here.
    task automatic dev_frame(input logic [7:0] b, input logic par_flip, input int nbits);
        logic [10:0] bits;
        logic        p;
        p    = (($countones(b) % 2) == 0) ^ par_flip;
        bits = {1'b1, p, b, 1'b0};
        if (nbits == 11) begin
            if ((($countones(b) + int'(p)) % 2) == 1) begin
                exp_q.push_back(evt_t'{1'b0, b});
                last_good = b;
            end else begin
                exp_q.push_back(evt_t'{1'b1, 8'h00});
            end
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == 1) check("busy_in_rx", {31'd0, busy}, 32'd1);
            dev_data_low = ~bits[i];
            repeat (H) @(negedge CLK);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge CLK);
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
        repeat (3 * H) @(negedge CLK);
    endtask

    // ---------------- host -> device transfer ----------------
    task automatic host_tx(input logic [7:0] b, input logic ack, input logic dup);
        logic [9:0] got;
        logic [7:0] e;
        int         n;
        int         low_cnt;
        got = '0;
        exp_tx_q.push_back(b);
        if (!ack) exp_q.push_back(evt_t'{1'b1, 8'h00});
        tx_data = b;
        tx_en   = 1'b1;
        @(negedge CLK);
        tx_en   = 1'b0;
        n = 0;
        while (ps2_clk_w !== 1'b0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("tx_inhibit_seen", {31'd0, (n < 200)}, 32'd1);
        low_cnt = 0;
        while (ps2_clk_w === 1'b0 && low_cnt < 2000) begin
            // A second request while busy must be ignored.
            tx_en = dup && (low_cnt == 5);
            if (tx_en) tx_data = ~b;
            @(negedge CLK);
            low_cnt++;
        end
        tx_en = 1'b0;
        check("tx_inhibit_len_ok", {31'd0, (low_cnt >= INH_US)}, 32'd1);
        check("tx_start_bit", {31'd0, ps2_data_w}, 32'd0);
        check("busy_in_tx", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            repeat (H) @(negedge CLK);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge CLK);
            dev_clk_low = 1'b0;
            repeat (H / 2) @(negedge CLK);
            got[k] = ps2_data_w;
        end
        if (ack) dev_data_low = 1'b1;
        repeat (H) @(negedge CLK);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge CLK);
        dev_clk_low = 1'b0;
        repeat (H / 2) @(negedge CLK);
        dev_data_low = 1'b0;
        if (exp_tx_q.size() == 0) begin
            check("tx_queue_nonempty", 32'd0, 32'd1);
        end else begin
            e = exp_tx_q.pop_front();
            check("tx_byte", {24'd0, got[7:0]}, {24'd0, e});
            check("tx_parity", {31'd0, got[8]}, {31'd0, (($countones(e) % 2) == 0)});
            check("tx_stop", {31'd0, got[9]}, 32'd1);
        end
        $display("tx byte captured 0x%02h parity %0d ack %0d", got[7:0], got[8], ack);
        repeat (4 * H) @(negedge CLK);
        check("busy_after_tx", {31'd0, busy}, 32'd0);
        if (dup) begin
            n = 0;
            repeat (300) begin
                @(negedge CLK);
                if (ps2_clk_w === 1'b0) n++;
            end
            check("no_second_tx", n, 32'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (5) @(negedge CLK);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_en",   {31'd0, rx_en},   32'd0);
        check("reset_busy",    {31'd0, busy},    32'd0);
        check("reset_err",     {31'd0, err},     32'd0);
        check("reset_clk_rel", {31'd0, ps2_clk_w},  32'd1);
        check("reset_dat_rel", {31'd0, ps2_data_w}, 32'd1);
        RST_X = 1'b1;
        repeat (20) @(negedge CLK);

        dev_frame(8'h1C, 1'b0, 11);
        check("busy_after_rx", {31'd0, busy}, 32'd0);
        dev_frame(8'hF0, 1'b0, 11);
        dev_frame(8'h1C, 1'b0, 11);
        dev_frame(8'h1C, 1'b1, 11);
        check("rx_data_held", {24'd0, rx_data}, 32'h1C);

        exp_q.push_back(evt_t'{1'b1, 8'h00});
        dev_frame(8'h77, 1'b0, 8);
        repeat (TO_US + 200) @(negedge CLK);
        check("busy_after_timeout", {31'd0, busy}, 32'd0);
        dev_frame(8'h5A, 1'b0, 11);

        host_tx(8'hED, 1'b1, 1'b0);
        host_tx(8'hFF, 1'b0, 1'b1);

        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 3) != 0)
                dev_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0), 11);
            else
                host_tx(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (200) @(negedge CLK);
        check("events_drained", exp_q.size(), 32'd0);
        check("tx_drained", exp_tx_q.size(), 32'd0);
        check("rx_data_final", {24'd0, rx_data}, {24'd0, last_good});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
